// File: rtl/spi_master_param.sv
// Parameterised SPI master. Each accepted start runs one frame in any of the four SPI modes.
// Chip selects are one-hot-low, and sclk and mosi are driven from registers.
module spi_master_param #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int NUM_SLAVES = 4,
    parameter bit LSB_FIRST  = 1'b0,
    localparam int SEL_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_cpol,
    input  logic                  i_cpha,
    input  logic [SEL_W-1:0]      i_slave_sel,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_miso,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [NUM_SLAVES-1:0] o_cs_n,
    output logic                  o_sclk,
    output logic                  o_mosi
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

    state_t                r_state, w_state_next;
    logic [DIV_W-1:0]      r_div;
    logic [BIT_W-1:0]      r_bit;
    logic                  r_cpol, r_cpha, r_sclk, r_mosi, r_done, r_err;
    logic [NUM_SLAVES-1:0] r_cs_n;
    logic [DATA_WIDTH-1:0] r_tx, r_rx, r_data_out;

    logic w_sel_ok, w_div_hit, w_trail_hit, w_leading, w_last;
    logic w_accept, w_reject, w_lead_done, w_tick, w_finish, w_sample, w_shift;

    function automatic logic tx_head(input logic [DATA_WIDTH-1:0] v);
        return LSB_FIRST ? v[0] : v[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] tx_shift(input logic [DATA_WIDTH-1:0] v);
        return LSB_FIRST ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rx_shift(input logic [DATA_WIDTH-1:0] v,
                                                       input logic b);
        return LSB_FIRST ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
    endfunction

    assign w_sel_ok    = ({1'b0, i_slave_sel} < (SEL_W + 1)'(NUM_SLAVES));
    assign w_div_hit   = (r_div == DIV_W'(CLK_DIV - 1));
    // TRAIL runs one cycle past CLK_DIV so the release lands on the completion edge
    assign w_trail_hit = (r_div == DIV_W'(CLK_DIV));
    assign w_leading   = (r_sclk == r_cpol);
    assign w_last      = w_tick & ~w_leading & (r_bit == BIT_W'(DATA_WIDTH - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start && w_sel_ok) w_state_next = S_LEAD;
            S_LEAD:  if (w_div_hit)           w_state_next = S_XFER;
            S_XFER:  if (w_last)              w_state_next = S_TRAIL;
            S_TRAIL: if (w_trail_hit)         w_state_next = S_IDLE;
            default:                          w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_lead_done = 1'b0;
        w_tick      = 1'b0;
        w_finish    = 1'b0;
        o_busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                w_accept = i_start & w_sel_ok;
                w_reject = i_start & ~w_sel_ok;
            end
            S_LEAD:  w_lead_done = w_div_hit;
            S_XFER:  w_tick      = w_div_hit;
            S_TRAIL: w_finish    = w_trail_hit;
            default: ;
        endcase
    end

    // cpha=0 samples on leading edges and shifts on trailing; cpha=1 is the reverse
    assign w_sample = w_tick & (r_cpha ? ~w_leading : w_leading);
    assign w_shift  = w_tick & (r_cpha ? w_leading : ~w_leading);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div      <= '0;
            r_bit      <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= '1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_done <= w_finish;
            r_err  <= w_reject;
            if (r_state == S_IDLE || w_lead_done || w_tick) r_div <= '0;
            else                                            r_div <= r_div + DIV_W'(1);
            if (w_accept) begin
                r_cpol <= i_cpol;
                r_cpha <= i_cpha;
                r_sclk <= i_cpol;
                r_mosi <= tx_head(i_data_in);
                r_bit  <= '0;
                r_cs_n <= ~(NUM_SLAVES'(1) << i_slave_sel);
            end else begin
                if (w_tick)               r_sclk <= ~r_sclk;
                if (w_tick && !w_leading) r_bit  <= r_bit + BIT_W'(1);
                if (w_shift)              r_mosi <= r_cpha ? tx_head(r_tx) : tx_head(tx_shift(r_tx));
                if (w_finish) begin
                    r_cs_n     <= '1;
                    r_data_out <= r_rx;
                end
            end
        end
    end

    // Shift registers carry no reset; data_out alone exposes the received word
    always_ff @(posedge i_clk) begin
        if (w_accept)     r_tx <= i_data_in;
        else if (w_shift) r_tx <= tx_shift(r_tx);
        if (w_sample)     r_rx <= rx_shift(r_rx, i_miso);
    end

    assign o_data_out = r_data_out;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_cs_n     = r_cs_n;
    assign o_sclk     = r_sclk;
    assign o_mosi     = r_mosi;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: default 8-bit instance with a mode-aware slave model,
// plus a 16-bit LSB-first, CLK_DIV=1, five-slave instance.
module tb_spi_master_param;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic       a_start, a_cpol, a_cpha, a_miso, a_busy, a_done, a_err, a_sclk, a_mosi;
    logic [1:0] a_sel;
    logic [7:0] a_din, a_dout;
    logic [3:0] a_cs_n;

    logic        b_start, b_cpol, b_cpha, b_busy, b_done, b_err, b_sclk, b_mosi;
    logic [2:0]  b_sel;
    logic [15:0] b_din, b_dout;
    logic [4:0]  b_cs_n;

    logic loop_en;
    logic s_miso = 1'b0;
    assign a_miso = loop_en ? a_mosi : s_miso;

    spi_master_param dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_cpol(a_cpol), .i_cpha(a_cpha),
        .i_slave_sel(a_sel), .i_data_in(a_din), .i_miso(a_miso), .o_data_out(a_dout),
        .o_busy(a_busy), .o_done(a_done), .o_err(a_err), .o_cs_n(a_cs_n),
        .o_sclk(a_sclk), .o_mosi(a_mosi)
    );

    spi_master_param #(.DATA_WIDTH(16), .CLK_DIV(1), .NUM_SLAVES(5), .LSB_FIRST(1'b1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_cpol(b_cpol), .i_cpha(b_cpha),
        .i_slave_sel(b_sel), .i_data_in(b_din), .i_miso(b_mosi), .o_data_out(b_dout),
        .o_busy(b_busy), .o_done(b_done), .o_err(b_err), .o_cs_n(b_cs_n),
        .o_sclk(b_sclk), .o_mosi(b_mosi)
    );

    // MSB-first SPI slave that always answers s_word; mode is set by the bench
    logic [7:0] s_word = 8'h3C;
    logic [7:0] s_rx = 8'h00;
    logic [7:0] s_txsh = 8'h00;
    logic       s_prev_sclk = 1'b0;
    logic       s_prev_act = 1'b0;
    logic       s_cpol = 1'b0;
    logic       s_cpha = 1'b0;
    logic       s_act;
    assign s_act = (a_cs_n != 4'hF);

    always @(negedge clk) begin
        s_prev_sclk <= a_sclk;
        s_prev_act  <= s_act;
        if (s_act && !s_prev_act) begin
            s_rx <= 8'h00;
            if (!s_cpha) begin
                s_miso <= s_word[7];
                s_txsh <= {s_word[6:0], 1'b0};
            end else begin
                s_txsh <= s_word;
            end
        end else if (s_act && (a_sclk != s_prev_sclk)) begin
            if ((s_prev_sclk == s_cpol) != s_cpha) begin
                s_rx <= {s_rx[6:0], a_mosi};
            end else begin
                s_miso <= s_txsh[7];
                s_txsh <= {s_txsh[6:0], 1'b0};
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       cpol;
        logic       cpha;
        logic       loopb;
        logic [1:0] sel;
        logic [7:0] din;
        logic [7:0] exp_out;
        logic [3:0] exp_cs;
    } vec_t;

    vec_t vecs [7];

    task automatic run_a(input vec_t v);
        int   lat;
        int   edges;
        int   errs;
        logic prev;
        @(negedge clk);
        a_cpol = v.cpol; a_cpha = v.cpha; a_sel = v.sel; a_din = v.din;
        loop_en = v.loopb; s_cpol = v.cpol; s_cpha = v.cpha; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        chk("busy_on_accept", a_busy, 1);
        chk("cs_n_lead", a_cs_n, v.exp_cs);
        chk("sclk_lead", a_sclk, v.cpol);
        lat = 0; edges = 0; errs = 0; prev = a_sclk;
        for (int k = 1; k <= 200 && lat == 0; k++) begin
            if (k == 5) begin
                a_cpol = ~v.cpol; a_cpha = ~v.cpha; a_sel = v.sel + 2'd1; a_din = ~v.din;
                a_start = 1'b1;
            end
            if (k == 6) a_start = 1'b0;
            @(posedge clk); #1;
            if (a_sclk != prev) edges++;
            prev = a_sclk;
            if (a_err) errs++;
            if (k == 20) chk("cs_n_mid", a_cs_n, v.exp_cs);
            if (a_done) lat = k;
        end
        chk("done_latency", lat, 37);
        chk("sclk_edges", edges, 16);
        chk("err_while_busy", errs, 0);
        chk("data_out", a_dout, v.exp_out);
        chk("cs_n_done", a_cs_n, 4'hF);
        chk("busy_done", a_busy, 0);
        chk("sclk_idle", a_sclk, v.cpol);
        if (!v.loopb) chk("slave_rx", s_rx, v.din);
        @(posedge clk); #1;
        chk("done_one_cycle", a_done, 0);
    endtask

    initial begin
        int   lat;
        int   bits;
        int   ones;
        int   dn;
        int   first;
        int   second;
        int   csh;
        int   errs;
        logic prev;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 2'd2, 8'hA5, 8'hA5, 4'b1011};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'hC3, 8'h3C, 4'b1110};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 2'd1, 8'hC3, 8'h3C, 4'b1101};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 2'd3, 8'hC3, 8'h3C, 4'b0111};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 2'd2, 8'hC3, 8'h3C, 4'b1011};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 4'b0111};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 2'd1, 8'hFF, 8'hFF, 4'b1101};

        rst_n = 1'b0; loop_en = 1'b1;
        a_start = 1'b0; a_cpol = 1'b0; a_cpha = 1'b0; a_sel = 2'd0; a_din = 8'h00;
        b_start = 1'b0; b_cpol = 1'b0; b_cpha = 1'b0; b_sel = 3'd0; b_din = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_cs_n", a_cs_n, 4'hF);
        chk("rst_sclk", a_sclk, 0);
        chk("rst_mosi", a_mosi, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_err", a_err, 0);
        chk("rst_dout", a_dout, 8'h00);
        chk("rst_b_cs_n", b_cs_n, 5'h1F);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_a(vecs[i]);

        // LSB-first, 16 bits, CLK_DIV=1, loopback
        @(negedge clk);
        b_cpol = 1'b0; b_cpha = 1'b0; b_sel = 3'd4; b_din = 16'h0001; b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        chk("b_mosi_first", b_mosi, 1);
        chk("b_cs_n", b_cs_n, 5'b01111);
        bits = 0; ones = 0; lat = 0; prev = b_sclk;
        for (int k = 1; k <= 100 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (!prev && b_sclk) begin
                bits++;
                if (bits == 1) chk("b_bit0", b_mosi, 1);
                else if (b_mosi) ones++;
            end
            prev = b_sclk;
            if (b_done) lat = k;
        end
        chk("b_bit_count", bits, 16);
        chk("b_later_ones", ones, 0);
        chk("b_latency", lat, 35);
        chk("b_dout", b_dout, 16'h0001);

        // Out-of-range slave select
        @(negedge clk);
        b_sel = 3'd5; b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        chk("err_pulse", b_err, 1);
        chk("err_busy", b_busy, 0);
        chk("err_cs_n", b_cs_n, 5'h1F);
        @(posedge clk); #1;
        chk("err_one_cycle", b_err, 0);
        chk("err_still_idle", b_busy, 0);
        chk("err_cs_n_after", b_cs_n, 5'h1F);

        // Asynchronous reset in the middle of bit 4
        @(negedge clk);
        a_cpol = 1'b0; a_cpha = 1'b0; a_sel = 2'd1; a_din = 8'h5A; loop_en = 1'b1; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", a_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", a_cs_n, 4'hF);
        chk("midrst_busy", a_busy, 0);
        chk("midrst_dout", a_dout, 8'h00);
        chk("midrst_sclk", a_sclk, 0);
        chk("midrst_done", a_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_a('{1'b0, 1'b0, 1'b1, 2'd1, 8'h5A, 8'h5A, 4'b1101});

        // start held through done: two frames with a single idle cycle between
        @(negedge clk);
        a_cpol = 1'b0; a_cpha = 1'b0; a_sel = 2'd0; a_din = 8'h96; loop_en = 1'b1; a_start = 1'b1;
        @(posedge clk); #1;
        dn = 0; first = 0; second = 0; csh = 0; errs = 0;
        for (int k = 1; k <= 90; k++) begin
            @(posedge clk); #1;
            if (k == 40) a_start = 1'b0;
            if (a_err) errs++;
            if (a_done) begin
                dn++;
                if (first == 0) first = k;
                else second = k;
            end
            if (dn == 1 && a_cs_n == 4'hF) csh++;
        end
        chk("b2b_done_count", dn, 2);
        chk("b2b_first_done", first, 37);
        chk("b2b_second_done", second, 75);
        chk("b2b_cs_high_cycles", csh, 1);
        chk("b2b_err", errs, 0);
        chk("b2b_dout", a_dout, 8'h96);
        chk("b2b_idle", a_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
